// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus between pc_fetch (master) and the memory (slave).
interface pc_fetch_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic [31:0] instr_rdata;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_ack,
        input  instr_rdata
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_ack,
        output instr_rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch sequencer: IDLE -> FETCH <-> EXEC,
// with branch/jump next-PC selection, alignment and fetch-timeout flags.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_if.master        bus,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic [1:0]        jump_dest,
    input  logic              bgezal,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       mem_data,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              align_err,
    output logic              timeout_err
);

    localparam int unsigned WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          req_q, req_d;
    logic          align_q, align_d;
    logic          tmo_q, tmo_d;
    logic [WW-1:0] wait_q, wait_d;

    logic [31:0]   pc_inc;
    logic [31:0]   br_off;
    logic [31:0]   br_tgt;
    logic [31:0]   j_tgt;
    logic [31:0]   nxt_raw;

    // Next-PC candidates; only consumed in EXEC.
    always_comb begin
        pc_inc  = pc_q + 32'd4;
        br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        br_tgt  = pc_inc + br_off;
        j_tgt   = {pc_inc[31:28], instr_q[25:0], 2'b00};
        nxt_raw = pc_inc;
        if (bgezal) begin
            nxt_raw = rs_data[31] ? pc_inc : br_tgt;
        end else begin
            case (jump_dest)
                2'b00:   nxt_raw = pc_inc;
                2'b01:   nxt_raw = mem_data;
                2'b10:   nxt_raw = j_tgt;
                default: nxt_raw = rs_data;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        req_d   = req_q;
        align_d = align_q;
        tmo_d   = tmo_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                wait_d  = '0;
            end
            S_FETCH: begin
                // req low here means the one-cycle gap after a timeout.
                if (!req_q) begin
                    req_d  = 1'b1;
                    wait_d = '0;
                end else if (bus.instr_ack) begin
                    instr_d = bus.instr_rdata;
                    state_d = S_EXEC;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    tmo_d  = 1'b1;
                    req_d  = 1'b0;
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EXEC: begin
                pc_d    = {nxt_raw[31:2], 2'b00};
                if (nxt_raw[1:0] != 2'b00) begin
                    align_d = 1'b1;
                end
                state_d = S_FETCH;
                req_d   = 1'b1;
                wait_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            align_q <= 1'b0;
            tmo_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            align_q <= align_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.instr_req  = req_q;
    assign bus.instr_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_inc;
    assign align_err      = align_q;
    assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: directed scenarios plus a next-PC model
// computed from the branch/jump rules with plain arithmetic.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MW     = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [1:0]  jump_dest;
    logic        bgezal;
    logic [31:0] rs_data;
    logic [31:0] mem_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        align_err;
    logic        timeout_err;

    pc_fetch_if bus();

    pc_fetch #(
        .RESET_PC (RST_PC),
        .MAX_WAIT (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .jump_dest   (jump_dest),
        .bgezal      (bgezal),
        .rs_data     (rs_data),
        .mem_data    (mem_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .align_err   (align_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] o_addr;
    logic [31:0] o_instr;
    logic [31:0] o_instr2;
    logic [31:0] o_pc;
    logic        o_req_exec;
    int          o_lat;
    int          o_pulses;
    logic [31:0] m_pc;
    logic        m_align;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        jump_dest = 2'($urandom);
        bgezal    = 1'($urandom);
        rs_data   = $urandom;
        mem_data  = $urandom;
    endtask

    // Next pc and whether it was misaligned, straight from the selection rules.
    function automatic logic [32:0] model_next(
        input logic [31:0] p,
        input logic [31:0] ins,
        input logic [1:0]  jd,
        input logic        bg,
        input logic [31:0] rs,
        input logic [31:0] mem
    );
        logic [31:0] p4;
        logic [31:0] n;
        int          s;
        p4 = p + 32'd4;
        s  = ins[15] ? int'(ins[15:0]) - 65536 : int'(ins[15:0]);
        if (bg && !rs[31])  n = p4 + 32'(s * 4);
        else if (bg)        n = p4;
        else if (jd == 2'd0) n = p4;
        else if (jd == 2'd1) n = mem;
        else if (jd == 2'd2) n = (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        else                n = rs;
        return {n[1:0] != 2'b00, n & 32'hFFFF_FFFC};
    endfunction

    // One instruction: w wait cycles, ack, then EXEC with the given controls.
    task automatic drive_instr(
        input int          w,
        input logic [31:0] rdata,
        input logic [1:0]  jd,
        input logic        bg,
        input logic [31:0] rs,
        input logic [31:0] mem
    );
        o_addr   = bus.instr_addr;
        o_lat    = -1;
        o_pulses = 0;
        for (int c = 0; c <= w; c++) begin
            junk();
            bus.instr_ack   = (c == w);
            bus.instr_rdata = (c == w) ? rdata : $urandom;
            step();
            if (instr_valid) begin
                o_pulses++;
                if (o_lat < 0) o_lat = c + 1;
            end
        end
        o_instr    = instr;
        o_req_exec = bus.instr_req;
        jump_dest  = jd;
        bgezal     = bg;
        rs_data    = rs;
        mem_data   = mem;
        bus.instr_ack   = 1'($urandom);
        bus.instr_rdata = $urandom;
        step();
        if (instr_valid) o_pulses++;
        o_pc     = pc;
        o_instr2 = instr;
        bus.instr_ack = 1'b0;
        junk();
    endtask

    task automatic set_pc(input logic [31:0] t);
        drive_instr(0, $urandom, 2'b11, 1'b0, t, $urandom);
        m_pc = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.instr_ack   = 1'b1;
        bus.instr_rdata = $urandom;
        junk();
        step();
        step();
        n_cmp++; if (pc !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (bus.instr_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.instr_req); end
        n_cmp++; if ({align_err, timeout_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", align_err, timeout_err); end
        n_cmp++; if (pc_plus4 !== RST_PC + 32'd4) begin n_bad++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, RST_PC + 32'd4); end
        rst = 1'b0;
        bus.instr_ack = 1'b0;
        step();
        n_cmp++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, RST_PC}) begin n_bad++; $display("FAIL first_fetch: got req=%b addr=%h want req=1 addr=%h", bus.instr_req, bus.instr_addr, RST_PC); end
        m_pc    = RST_PC;
        m_align = 1'b0;
    endtask

    task automatic test_seq();
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            drive_instr(0, r, 2'b00, 1'b0, $urandom, $urandom);
            n_cmp++; if (o_addr !== RST_PC + 32'(4 * i)) begin n_bad++; $display("FAIL seq_addr%0d: got %h want %h", i, o_addr, RST_PC + 32'(4 * i)); end
            n_cmp++; if (o_lat !== 1 || o_pulses !== 1) begin n_bad++; $display("FAIL seq_valid%0d: got lat=%0d pulses=%0d want lat=1 pulses=1", i, o_lat, o_pulses); end
            n_cmp++; if (o_instr !== r || o_req_exec !== 1'b0) begin n_bad++; $display("FAIL seq_instr%0d: got %h req=%b want %h req=0", i, o_instr, o_req_exec, r); end
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic test_wait();
        logic [31:0] r;
        r = $urandom;
        drive_instr(3, r, 2'b00, 1'b0, $urandom, $urandom);
        n_cmp++; if (o_lat !== 4) begin n_bad++; $display("FAIL wait_latency: got %0d want 4", o_lat); end
        n_cmp++; if (o_instr !== r) begin n_bad++; $display("FAIL wait_instr: got %h want %h", o_instr, r); end
        n_cmp++; if (o_pc !== m_pc + 32'd4) begin n_bad++; $display("FAIL wait_pc: got %h want %h", o_pc, m_pc + 32'd4); end
        m_pc = m_pc + 32'd4;
    endtask

    task automatic test_branch();
        set_pc(32'h0000_0100);
        drive_instr(0, 32'h0000_FFFF, 2'($urandom), 1'b1, 32'd5, $urandom);
        n_cmp++; if (o_pc !== 32'h0000_0100) begin n_bad++; $display("FAIL bgezal_taken: got %h want 00000100", o_pc); end
        drive_instr(0, 32'h0000_FFFF, 2'($urandom), 1'b1, 32'h8000_0000, $urandom);
        n_cmp++; if (o_pc !== 32'h0000_0104) begin n_bad++; $display("FAIL bgezal_not_taken: got %h want 00000104", o_pc); end
        n_cmp++; if (align_err !== 1'b0) begin n_bad++; $display("FAIL branch_align: got %b want 0", align_err); end
        m_pc = 32'h0000_0104;
    endtask

    task automatic test_jump_align();
        set_pc(32'h4000_0010);
        drive_instr(0, 32'h0800_0010, 2'b10, 1'b0, $urandom, $urandom);
        n_cmp++; if (o_pc !== 32'h4000_0040) begin n_bad++; $display("FAIL jump_target: got %h want 40000040", o_pc); end
        n_cmp++; if (align_err !== 1'b0) begin n_bad++; $display("FAIL jump_align: got %b want 0", align_err); end
        drive_instr(0, $urandom, 2'b01, 1'b0, $urandom, 32'h0000_0202);
        n_cmp++; if (o_pc !== 32'h0000_0200) begin n_bad++; $display("FAIL misaligned_pc: got %h want 00000200", o_pc); end
        n_cmp++; if (align_err !== 1'b1) begin n_bad++; $display("FAIL misaligned_flag: got %b want 1", align_err); end
        m_pc    = 32'h0000_0200;
        m_align = 1'b1;
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        n_cmp++; if (pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc_plus4: got %h want 00000000", pc_plus4); end
        drive_instr(0, $urandom, 2'b00, 1'b0, $urandom, $urandom);
        n_cmp++; if (o_addr !== 32'hFFFF_FFFC || o_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc: got addr=%h next=%h want FFFFFFFC/00000000", o_addr, o_pc); end
        m_pc = 32'h0;
    endtask

    task automatic test_random();
        logic [32:0] e;
        logic [31:0] r;
        logic [31:0] rs;
        logic [31:0] mem;
        logic [1:0]  jd;
        logic        bg;
        int          w;
        for (int i = 0; i < 40; i++) begin
            w   = $urandom_range(0, MW - 1);
            r   = $urandom;
            bg  = ($urandom_range(0, 3) == 0);
            jd  = 2'($urandom);
            rs  = $urandom;
            mem = $urandom;
            if ($urandom_range(0, 1) == 1) rs[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) mem[1:0] = 2'b00;
            e = model_next(m_pc, r, jd, bg, rs, mem);
            drive_instr(w, r, jd, bg, rs, mem);
            m_align = m_align | e[32];
            n_cmp++; if (o_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr%0d: got %h want %h", i, o_addr, m_pc); end
            n_cmp++; if (o_lat !== w + 1 || o_pulses !== 1) begin n_bad++; $display("FAIL rnd_valid%0d: got lat=%0d pulses=%0d want lat=%0d pulses=1", i, o_lat, o_pulses, w + 1); end
            n_cmp++; if (o_instr !== r || o_instr2 !== r) begin n_bad++; $display("FAIL rnd_instr%0d: got %h/%h want %h", i, o_instr, o_instr2, r); end
            n_cmp++; if (o_pc !== e[31:0]) begin n_bad++; $display("FAIL rnd_pc%0d: got %h want %h", i, o_pc, e[31:0]); end
            n_cmp++; if (align_err !== m_align) begin n_bad++; $display("FAIL rnd_align%0d: got %b want %b", i, align_err, m_align); end
            m_pc = e[31:0];
        end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rnd_no_timeout: got %b want 0", timeout_err); end
    endtask

    task automatic test_timeout();
        logic [31:0] a;
        logic [31:0] r;
        a = bus.instr_addr;
        bus.instr_ack = 1'b0;
        for (int k = 0; k < MW - 1; k++) begin
            junk();
            step();
        end
        n_cmp++; if ({bus.instr_req, timeout_err} !== 2'b10) begin n_bad++; $display("FAIL timeout_early: got req=%b tmo=%b want req=1 tmo=0", bus.instr_req, timeout_err); end
        step();
        n_cmp++; if ({bus.instr_req, timeout_err} !== 2'b01) begin n_bad++; $display("FAIL timeout_fire: got req=%b tmo=%b want req=0 tmo=1", bus.instr_req, timeout_err); end
        step();
        n_cmp++; if ({bus.instr_req, bus.instr_addr} !== {1'b1, a}) begin n_bad++; $display("FAIL timeout_reissue: got req=%b addr=%h want req=1 addr=%h", bus.instr_req, bus.instr_addr, a); end
        r = $urandom;
        drive_instr(0, r, 2'b00, 1'b0, $urandom, $urandom);
        n_cmp++; if (o_lat !== 1 || o_instr !== r || o_pc !== a + 32'd4) begin n_bad++; $display("FAIL timeout_resume: got lat=%0d instr=%h pc=%h want 1/%h/%h", o_lat, o_instr, o_pc, r, a + 32'd4); end
        m_pc = a + 32'd4;
    endtask

    task automatic test_reset_abort();
        set_pc(32'h0000_0040);
        n_cmp++; if (bus.instr_addr !== 32'h0000_0040) begin n_bad++; $display("FAIL abort_setup: got %h want 00000040", bus.instr_addr); end
        bus.instr_ack   = 1'b1;
        bus.instr_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        step();
        n_cmp++; if (pc !== RST_PC || instr !== 32'h0) begin n_bad++; $display("FAIL abort_state: got pc=%h instr=%h want %h/00000000", pc, instr, RST_PC); end
        n_cmp++; if ({instr_valid, bus.instr_req, align_err, timeout_err} !== 4'b0000) begin n_bad++; $display("FAIL abort_flags: got %b%b%b%b want 0000", instr_valid, bus.instr_req, align_err, timeout_err); end
        rst = 1'b0;
        bus.instr_ack = 1'b0;
        step();
        n_cmp++; if ({instr_valid, bus.instr_req, bus.instr_addr} !== {2'b01, RST_PC}) begin n_bad++; $display("FAIL abort_refetch: got valid=%b req=%b addr=%h want 0/1/%h", instr_valid, bus.instr_req, bus.instr_addr, RST_PC); end
    endtask

    initial begin
        rst             = 1'b1;
        bus.instr_ack   = 1'b0;
        bus.instr_rdata = '0;
        junk();
        test_reset();
        test_seq();
        test_wait();
        test_branch();
        test_jump_align();
        test_wrap();
        test_random();
        test_timeout();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the address of the first fetch after reset.
REQ-002 Parameter MAX_WAIT, default 15, the number of wait cycles without instr_ack before the fetch timeout fires.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 instr_req  out  1  fetch request to instruction memory.
REQ-006 instr_addr  out  32  fetch address; always equal to pc.
REQ-007 instr_ack  in  1  instruction memory response strobe.
REQ-008 instr_rdata  in  32  instruction word; valid when instr_ack=1.
REQ-009 instr  out  32  latched instruction word presented to decode and control.
REQ-010 instr_valid  out  1  one-cycle strobe marking the execute cycle of instr.
REQ-011 jump_dest  in  2  next-PC select from control: 00 pc+4, 01 mem_data, 10 jump target, 11 rs_data.
REQ-012 bgezal  in  1  branch-on-rs>=0-and-link indication from control.
REQ-013 rs_data  in  32  register rs value.
REQ-014 mem_data  in  32  data memory read value (jmadd target).
REQ-015 pc  out  32  address of the current instruction.
REQ-016 pc_plus4  out  32  pc+4, the link value for writeback.
REQ-017 align_err  out  1  sticky flag: a misaligned next-PC was produced.
REQ-018 timeout_err  out  1  sticky flag: a fetch exceeded MAX_WAIT.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH and EXEC; IDLE is entered only from reset and goes to FETCH on the next cycle.
REQ-020 In FETCH, instr_req SHALL be 1 and instr_addr SHALL equal pc; instr_ack=1 latches instr_rdata into instr and moves to EXEC next cycle.
REQ-021 In EXEC, instr_valid SHALL be 1 for exactly one cycle, instr_req SHALL be 0, pc SHALL load next_pc, and the state SHALL return to FETCH.
REQ-022 Minimum instruction period SHALL be 2 cycles (ack in the first FETCH cycle); every wait cycle adds one.
REQ-023 The jump target for jump_dest=10 SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-024 The branch target SHALL be pc_plus4 + (sign-extended instr[15:0] << 2).
REQ-025 bgezal=1 with rs_data[31]=0 SHALL select the branch target and override jump_dest; bgezal=1 with rs_data[31]=1 SHALL select pc+4.
REQ-026 Otherwise next_pc SHALL follow jump_dest per REQ-011, with control inputs sampled only in the EXEC cycle.
REQ-027 All address arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFC with pc+4 selected wraps to 0.
REQ-028 If next_pc[1:0]≠00, the block SHALL load next_pc with bits [1:0] forced to 00 and set align_err.
REQ-029 instr_ack outside FETCH SHALL be ignored and SHALL leave instr unchanged.
REQ-030 A wait counter SHALL clear on entry to FETCH; if it reaches MAX_WAIT without ack, the block SHALL set timeout_err, drop instr_req for one cycle and re-issue the fetch at the same pc.
REQ-031 pc_plus4 SHALL be combinational pc+4.

Reset
REQ-032 With rst=1 at a rising edge, the block SHALL set state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, instr_req=0, align_err=0, timeout_err=0 and wait counter=0.
REQ-033 Reset in FETCH or EXEC SHALL abort the operation: the pending ack is discarded and no pc update occurs.
REQ-034 rst SHALL override every other input in the same cycle.

Verification
REQ-035 Reset release, memory acks immediately -> instr_addr sequence 0, 4, 8; instr_valid pulses every 2nd cycle.
REQ-036 Ack after 3 wait cycles -> instr_valid 4 cycles after instr_req rises; instr equals instr_rdata at ack.
REQ-037 pc=0x100, bgezal=1, rs_data=5, imm=0xFFFF -> next pc=0x100; with rs_data=0x8000_0000 -> next pc=0x104.
REQ-038 pc=0x4000_0010, jump_dest=10, instr[25:0]=0x10 -> next pc=0x4000_0040; jump_dest=01, mem_data=0x202 -> pc=0x200 and align_err=1.
REQ-039 No ack for MAX_WAIT cycles -> timeout_err=1, instr_req low for 1 cycle, then re-asserted with the same instr_addr.
REQ-040 rst asserted in the cycle the ack arrives -> pc=RESET_PC, instr=0 and no instr_valid pulse.
